lap_recorder: RTL and testbench



---
 rtl/stopwatch_pkg.sv | 21 ++
 rtl/lap_recorder_lap_mem.sv | 26 ++
 rtl/lap_recorder.sv | 165 ++++++++++++++++
 tb/tb_lap_recorder.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared stopwatch types and BCD time-word constants
package stopwatch_pkg;

    // Control states of the lap recorder.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        RECALL = 2'd3
    } sw_state_t;

    // Time word layout: {m1,m0,s1,s0,f1,f0}, f0 in the low nibble.
    localparam int DIGIT_W = 4;
    localparam int DIGIT_N = 6;
    localparam int TIME_W  = DIGIT_W * DIGIT_N;

    // Nibble code the display driver renders as an unlit digit.
    localparam logic [DIGIT_W-1:0] BLANK_DIGIT = 4'hF;
    localparam logic [TIME_W-1:0]  BLANK_TIME  = {DIGIT_N{BLANK_DIGIT}};

endpackage

// File: rtl/lap_recorder_lap_mem.sv
// rtl/lap_recorder_lap_mem.sv - DEPTH x TW lap storage, synchronous write, registered read
// Ports: clk; we/waddr/wdata write side; raddr in, rdata out one cycle later.
// Contents are not reset; only entries below the recorder's lap count are meaningful.
module lap_mem #(
    parameter int DEPTH = 4,
    parameter int TW    = 24,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [TW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [TW-1:0] rdata
);

    logic [TW-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/lap_recorder.sv
// rtl/lap_recorder.sv - run/pause/recall control, lap capture and display select for the stopwatch
// Ports: clk, reset_n (async, active-high); tick, start_p, lap_p, clear_p pulses;
//        live_time from the counter chain; run_en/counter_clr to the counter chain;
//        disp_time/disp_lap to the display driver; lap_count/lap_full status.
module lap_recorder
    import stopwatch_pkg::*;
#(
    parameter int DEPTH      = 4,
    parameter int HOLD_TICKS = 200,
    parameter int TW         = TIME_W
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   tick,
    input  logic                   start_p,
    input  logic                   lap_p,
    input  logic                   clear_p,
    input  logic [TW-1:0]          live_time,
    output logic                   run_en,
    output logic                   counter_clr,
    output logic [TW-1:0]          disp_time,
    output logic [2:0]             disp_lap,
    output logic [$clog2(DEPTH):0] lap_count,
    output logic                   lap_full
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int HW = $clog2(HOLD_TICKS + 1);
    localparam logic [CW-1:0] FULL      = CW'(DEPTH);
    localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_TICKS);

    sw_state_t     state;
    logic [CW-1:0] rec_idx;
    logic [HW-1:0] hold_cnt;
    logic [TW-1:0] freeze_q;
    logic [TW-1:0] rd_data;
    logic [AW-1:0] rd_addr;
    logic          do_clear;
    logic          do_start;
    logic          do_lap;
    logic          mem_we;

    // Only the highest-priority pulse in a cycle is acted on.
    assign do_clear = clear_p;
    assign do_start = start_p & ~clear_p;
    assign do_lap   = lap_p & ~clear_p & ~start_p;

    assign lap_full = (lap_count == FULL);

    // State is already IDLE while reset is high, so no write can slip through.
    assign mem_we = (state == RUN) && do_lap && !lap_full;

    // Read address follows the index the FSM is about to hold, so the
    // registered read lands in the same cycle the new disp_lap appears.
    always_comb begin
        rd_addr = rec_idx[AW-1:0];
        if (state == PAUSED && do_lap) begin
            rd_addr = '0;
        end else if (state == RECALL && do_lap) begin
            rd_addr = AW'(rec_idx + CW'(1));
        end
    end

    lap_mem #(
        .DEPTH (DEPTH),
        .TW    (TW),
        .AW    (AW)
    ) u_lap_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr (lap_count[AW-1:0]),
        .wdata (live_time),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            state       <= IDLE;
            run_en      <= 1'b0;
            counter_clr <= 1'b0;
            disp_lap    <= 3'd0;
            lap_count   <= '0;
            rec_idx     <= '0;
            hold_cnt    <= '0;
            freeze_q    <= '0;
        end else begin
            counter_clr <= 1'b0;
            if (tick && hold_cnt != '0) begin
                hold_cnt <= hold_cnt - HW'(1);
            end

            case (state)
                IDLE: begin
                    if (do_clear) begin
                        counter_clr <= 1'b1;
                        lap_count   <= '0;
                    end else if (do_start) begin
                        state  <= RUN;
                        run_en <= 1'b1;
                    end
                end

                RUN: begin
                    if (do_start) begin
                        state  <= PAUSED;
                        run_en <= 1'b0;
                    end else if (mem_we) begin
                        lap_count <= lap_count + CW'(1);
                        freeze_q  <= live_time;
                        hold_cnt  <= HOLD_LOAD;
                    end
                end

                PAUSED: begin
                    if (do_clear) begin
                        state       <= IDLE;
                        counter_clr <= 1'b1;
                        lap_count   <= '0;
                        hold_cnt    <= '0;
                    end else if (do_start) begin
                        state  <= RUN;
                        run_en <= 1'b1;
                    end else if (do_lap && lap_count != '0) begin
                        state    <= RECALL;
                        rec_idx  <= '0;
                        disp_lap <= 3'd1;
                        hold_cnt <= '0;
                    end
                end

                RECALL: begin
                    if (do_clear) begin
                        state    <= PAUSED;
                        disp_lap <= 3'd0;
                    end else if (do_lap) begin
                        rec_idx <= rec_idx + CW'(1);
                        if (rec_idx + CW'(1) == lap_count) begin
                            state    <= PAUSED;
                            disp_lap <= 3'd0;
                        end else begin
                            disp_lap <= 3'(rec_idx + CW'(2));
                        end
                    end
                end

                default: begin
                    state  <= IDLE;
                    run_en <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        disp_time = live_time;
        if (state == RECALL) begin
            disp_time = rd_data;
        end else if (hold_cnt != '0) begin
            disp_time = freeze_q;
        end
    end

endmodule

// File: tb/tb_lap_recorder.sv
// tb/tb_lap_recorder.sv - self-checking bench for lap_recorder against a behavioural model
module tb_lap_recorder;

    localparam int DEPTH = 4;
    localparam int HOLD  = 200;
    localparam int TW    = 24;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          tick = 1'b0;
    logic          start_p = 1'b0;
    logic          lap_p = 1'b0;
    logic          clear_p = 1'b0;
    logic [TW-1:0] live_time = '0;
    logic          run_en;
    logic          counter_clr;
    logic [TW-1:0] disp_time;
    logic [2:0]    disp_lap;
    logic [2:0]    lap_count;
    logic          lap_full;

    always #5 clk = ~clk;

    lap_recorder #(
        .DEPTH      (DEPTH),
        .HOLD_TICKS (HOLD),
        .TW         (TW)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .tick        (tick),
        .start_p     (start_p),
        .lap_p       (lap_p),
        .clear_p     (clear_p),
        .live_time   (live_time),
        .run_en      (run_en),
        .counter_clr (counter_clr),
        .disp_time   (disp_time),
        .disp_lap    (disp_lap),
        .lap_count   (lap_count),
        .lap_full    (lap_full)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: 0 idle, 1 run, 2 paused, 3 recall.
    int            m_state;
    logic [TW-1:0] m_laps[$];
    int            m_hold;
    logic [TW-1:0] m_frz;
    int            m_idx;
    bit            m_clr;

    task automatic model_reset();
        m_state = 0;
        m_laps.delete();
        m_hold = 0;
        m_frz  = '0;
        m_idx  = 0;
        m_clr  = 1'b0;
    endtask

    task automatic model_step();
        int act;
        if (reset_n) begin
            model_reset();
            return;
        end
        act = clear_p ? 1 : start_p ? 2 : lap_p ? 3 : 0;
        m_clr = 1'b0;
        if (tick && m_hold > 0) m_hold--;
        case (m_state)
            0: begin
                if (act == 1) begin
                    m_clr = 1'b1;
                    m_laps.delete();
                end else if (act == 2) m_state = 1;
            end
            1: begin
                if (act == 2) m_state = 2;
                else if (act == 3 && m_laps.size() < DEPTH) begin
                    m_laps.push_back(live_time);
                    m_frz  = live_time;
                    m_hold = HOLD;
                end
            end
            2: begin
                if (act == 1) begin
                    m_clr = 1'b1;
                    m_laps.delete();
                    m_state = 0;
                    m_hold = 0;
                end else if (act == 2) m_state = 1;
                else if (act == 3 && m_laps.size() > 0) begin
                    m_state = 3;
                    m_idx = 0;
                    m_hold = 0;
                end
            end
            default: begin
                if (act == 1) m_state = 2;
                else if (act == 3) begin
                    m_idx++;
                    if (m_idx == m_laps.size()) m_state = 2;
                end
            end
        endcase
    endtask

    function automatic logic [TW-1:0] exp_time();
        if (m_state == 3) return m_laps[m_idx];
        if (m_hold > 0) return m_frz;
        return live_time;
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("run_en", run_en, m_state == 1);
            chk("counter_clr", counter_clr, m_clr);
            chk("disp_lap", disp_lap, (m_state == 3) ? m_idx + 1 : 0);
            chk("lap_count", lap_count, m_laps.size());
            chk("lap_full", lap_full, m_laps.size() == DEPTH);
            chk("disp_time", disp_time, exp_time());
            chk("clr_with_run", counter_clr & run_en, 0);
        end
    end

    task automatic cyc(input bit s, input bit l, input bit c, input bit t);
        start_p = s;
        lap_p   = l;
        clear_p = c;
        tick    = t;
        @(posedge clk);
        model_step();
        #1;
        start_p = 1'b0;
        lap_p   = 1'b0;
        clear_p = 1'b0;
        tick    = 1'b0;
        #1;
    endtask

    task automatic set_live(input logic [TW-1:0] v);
        live_time = v;
        #1;
    endtask

    logic [TW-1:0] vals [4] = '{24'h000011, 24'h000222, 24'h003333, 24'h010101};
    int cnt;

    initial begin
        reset_n = 1'b1;
        model_reset();
        live_time = 24'h123456;
        #1;
        chk_en = 1'b1;
        cyc(0, 0, 0, 0);
        cyc(0, 0, 0, 0);
        chk("rst_run_en", run_en, 0);
        chk("rst_counter_clr", counter_clr, 0);
        chk("rst_disp_lap", disp_lap, 0);
        chk("rst_lap_count", lap_count, 0);
        chk("rst_lap_full", lap_full, 0);
        chk("rst_disp_time", disp_time, 24'h123456);
        reset_n = 1'b0;
        #1;
        cyc(0, 0, 0, 0);

        // Basic run: 500 ticks between start and stop.
        cyc(1, 0, 0, 0);
        chk("run_started", run_en, 1);
        cnt = 0;
        for (int i = 0; i < 500; i++) begin
            cyc(0, 0, 0, 1);
            if (run_en) cnt++;
        end
        chk("run_cycles", cnt, 500);
        cyc(1, 0, 0, 0);
        chk("run_stopped", run_en, 0);

        // Lap capture and freeze duration.
        cyc(1, 0, 0, 0);
        set_live(24'h000123);
        cyc(0, 1, 0, 0);
        chk("lap_count_1", lap_count, 1);
        set_live(24'h000999);
        chk("frozen", disp_time, 24'h000123);
        for (int i = 0; i < 199; i++) cyc(0, 0, 0, 1);
        chk("frozen_199", disp_time, 24'h000123);
        cyc(0, 0, 0, 1);
        chk("unfrozen", disp_time, 24'h000999);

        // Overflow: pause, clear, restart, five laps.
        cyc(1, 0, 0, 0);
        cyc(0, 0, 1, 0);
        chk("clr_pulse", counter_clr, 1);
        chk("clr_laps", lap_count, 0);
        cyc(0, 0, 0, 0);
        chk("clr_one_cycle", counter_clr, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            set_live(vals[i]);
            cyc(0, 1, 0, 0);
        end
        for (int i = 0; i < HOLD; i++) cyc(0, 0, 0, 1);
        set_live(24'h004444);
        cyc(0, 1, 0, 0);
        chk("ovf_count", lap_count, 4);
        chk("ovf_full", lap_full, 1);
        set_live(24'h005555);
        chk("ovf_no_freeze", disp_time, 24'h005555);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) begin
            cyc(0, 1, 0, 0);
            chk("ovf_recall_lap", disp_lap, i + 1);
            chk("ovf_recall_time", disp_time, vals[i]);
        end
        cyc(0, 1, 0, 0);
        chk("ovf_recall_end", disp_lap, 0);
        chk("ovf_recall_live", disp_time, 24'h005555);

        // Recall with three laps; freeze survives pause, cancelled by recall.
        cyc(0, 0, 1, 0);
        cyc(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            set_live(vals[3 - i]);
            cyc(0, 1, 0, 0);
        end
        cyc(1, 0, 0, 0);
        set_live(24'h777777);
        chk("freeze_across_pause", disp_time, vals[1]);
        for (int i = 0; i < 3; i++) begin
            cyc(0, 1, 0, 0);
            chk("recall_lap", disp_lap, i + 1);
            chk("recall_time", disp_time, vals[3 - i]);
        end
        cyc(0, 1, 0, 0);
        chk("recall_end", disp_lap, 0);
        chk("freeze_cancelled", disp_time, 24'h777777);

        // Priority: clear beats start while paused.
        cyc(1, 0, 1, 0);
        chk("prio_clr", counter_clr, 1);
        chk("prio_run_en", run_en, 0);
        chk("prio_laps", lap_count, 0);
        cyc(0, 0, 0, 0);
        chk("prio_clr_done", counter_clr, 0);
        chk("prio_idle", run_en, 0);

        // Clear ignored while running.
        cyc(1, 0, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        chk("run_clr_ignored", counter_clr, 0);
        chk("run_clr_run_en", run_en, 1);
        chk("run_clr_laps", lap_count, 1);

        // Reset mid-run acts at once.
        reset_n = 1'b1;
        model_reset();
        #1;
        chk("mid_rst_run_en", run_en, 0);
        chk("mid_rst_disp_lap", disp_lap, 0);
        chk("mid_rst_laps", lap_count, 0);
        chk("mid_rst_time", disp_time, live_time);
        cyc(0, 0, 0, 0);
        reset_n = 1'b0;
        #1;
        for (int i = 0; i < 3; i++) begin
            cyc(0, 0, 0, 0);
            chk("post_rst_clr", counter_clr, 0);
            chk("post_rst_run_en", run_en, 0);
        end

        // Randomized traffic against the model.
        for (int i = 0; i < 8000; i++) begin
            live_time = 24'($urandom);
            if ($urandom_range(999) == 0) begin
                reset_n = 1'b1;
                model_reset();
                cyc(0, 0, 0, 0);
                reset_n = 1'b0;
                #1;
            end
            cyc($urandom_range(99) < 4, $urandom_range(99) < 8,
                $urandom_range(99) < 3, $urandom_range(99) < 60);
        end

        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
